// File: rtl/reg_writeback.sv
// Register-file write front end: merges ALU results with FIFO-buffered load results
// onto a single registered write port and exports a pending-load scoreboard.
module reg_writeback #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5,
  parameter int lsu_depth      = 4,
  parameter int starve_limit   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alu_valid,
  input  logic [reg_addr_width-1:0]          alu_rd,
  input  logic [word_width-1:0]              alu_data,
  output logic                               alu_stall,
  input  logic                               lsu_valid,
  output logic                               lsu_ready,
  input  logic [reg_addr_width-1:0]          lsu_rd,
  input  logic [word_width-1:0]              lsu_data,
  output logic                               wren,
  output logic [reg_addr_width-1:0]          wr_addr,
  output logic [word_width-1:0]              wr_data,
  output logic [(2**reg_addr_width)-1:0]     pending,
  output logic [$clog2(lsu_depth):0]         lsu_count
);

  localparam int PTR_W = $clog2(lsu_depth);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(starve_limit + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(lsu_depth);

  logic [reg_addr_width-1:0] fifo_rd_q   [lsu_depth];
  logic [word_width-1:0]     fifo_data_q [lsu_depth];

  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [STV_W-1:0]          starve_q, starve_d;
  logic                      alu_stall_q, alu_stall_d;
  logic                      wren_q, wren_d;
  logic [reg_addr_width-1:0] wr_addr_q, wr_addr_d;
  logic [word_width-1:0]     wr_data_q, wr_data_d;

  logic                      nonempty, can_accept, alu_eff;
  logic                      take_head, take_alu, enq;
  logic [lsu_depth-1:0]      entry_valid;

  // An entry is live when its distance from the read pointer is below the occupancy.
  generate
    for (genvar gi = 0; gi < lsu_depth; gi++) begin : g_valid
      logic [PTR_W-1:0] off;
      assign off             = PTR_W'(gi) - rd_ptr_q;
      assign entry_valid[gi] = {1'b0, off} < count_q;
    end
  endgenerate

  always_comb begin
    pending = '0;
    for (int i = 0; i < lsu_depth; i++) begin
      if (entry_valid[i]) pending[fifo_rd_q[i]] = 1'b1;
    end
  end

  assign nonempty   = (count_q != '0);
  assign can_accept = (count_q != FULL);
  assign lsu_ready  = reset & can_accept;
  assign enq        = lsu_valid & can_accept & (lsu_rd != '0);
  assign alu_eff    = alu_valid & (alu_rd != '0) & ~alu_stall_q;
  // A stalled ALU can never be effective, so the head wins whenever the ALU does not.
  assign take_head  = nonempty & (alu_stall_q | ~alu_eff);
  assign take_alu   = alu_eff & ~take_head;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    wren_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (take_head) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq)       wr_ptr_d = wr_ptr_q + PTR_W'(1);

    unique case ({enq, take_head})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (take_head || !nonempty) starve_d = '0;
    else if (take_alu)          starve_d = starve_q + STV_W'(1);

    if (take_head) begin
      wren_d    = 1'b1;
      wr_addr_d = fifo_rd_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end else if (take_alu) begin
      wren_d    = 1'b1;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end
  end

  // Looking at the next counter value makes the stall cover exactly starve_limit ALU wins.
  assign alu_stall_d = (starve_d == STV_W'(starve_limit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      wren_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      wren_q      <= wren_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  assign alu_stall = alu_stall_q;
  assign wren      = wren_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign lsu_count = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback: a queue-based reference model
// predicts writes into a scoreboard that a negedge monitor drains and compares.
module tb_reg_writeback;
  localparam int W  = 32;
  localparam int A  = 5;
  localparam int D  = 4;
  localparam int L  = 4;
  localparam int NR = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           alu_valid = 1'b0;
  logic [A-1:0]   alu_rd = '0;
  logic [W-1:0]   alu_data = '0;
  logic           alu_stall;
  logic           lsu_valid = 1'b0;
  logic           lsu_ready;
  logic [A-1:0]   lsu_rd = '0;
  logic [W-1:0]   lsu_data = '0;
  logic           wren;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic [NR-1:0]  pending;
  logic [2:0]     lsu_count;

  reg_writeback #(.word_width(W), .reg_addr_width(A), .lsu_depth(D), .starve_limit(L)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .lsu_count(lsu_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A-1:0] rd;
    logic [W-1:0] data;
  } wr_t;

  int      n_checks = 0;
  int      n_pass   = 0;
  wr_t     mq[$];
  wr_t     exp_q[$];
  int      m_starve = 0;
  bit      m_stall  = 1'b0;
  bit      m_wren   = 1'b0;
  wr_t     m_last   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_wren   = 1'b0;
    m_last   = '0;
  endtask

  // Predicts what the coming clock edge does, from the current inputs and model state.
  task automatic model_step();
    bit  has_head = (mq.size() > 0);
    bit  room     = (mq.size() < D);
    bit  alu_ok   = alu_valid && (alu_rd != 0) && !m_stall;
    bit  popped   = 1'b0;
    wr_t w;
    m_wren = 1'b0;
    if (has_head && (m_stall || !alu_ok)) begin
      w = mq.pop_front();
      popped = 1'b1;
      m_wren = 1'b1;
    end else if (alu_ok) begin
      w.rd = alu_rd;
      w.data = alu_data;
      m_wren = 1'b1;
      if (has_head) m_starve++;
    end
    if (popped || !has_head) m_starve = 0;
    m_stall = (m_starve == L);
    if (m_wren) begin
      exp_q.push_back(w);
      m_last = w;
    end
    if (lsu_valid && room && lsu_rd != 0) mq.push_back('{rd: lsu_rd, data: lsu_data});
  endtask

  task automatic cyc(input bit av, input logic [A-1:0] ard, input logic [W-1:0] ad,
                     input bit lv, input logic [A-1:0] lrd, input logic [W-1:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    chk("lsu_count", 64'(lsu_count), 64'(mq.size()));
    chk("pending", 64'(pending), 64'(m_pending()));
    chk("lsu_ready", 64'(lsu_ready), 64'(reset && mq.size() < D));
    chk("alu_stall", 64'(alu_stall), 64'(m_stall));
    chk("wren", 64'(wren), 64'(m_wren));
    if (wren) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.rd));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        $display("write r%0d = 0x%08h (exp r%0d = 0x%08h)", wr_addr, wr_data, e.rd, e.data);
      end
    end else begin
      chk("hold_addr", 64'(wr_addr), 64'(m_last.rd));
      chk("hold_data", 64'(wr_data), 64'(m_last.data));
    end
  end

  initial begin
    logic [A-1:0] r_ard;
    logic [W-1:0] r_ad;
    bit           r_av;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // ALU only: write visible one cycle later, then gone
    cyc(1'b1, 5'd5, 32'h69, 1'b0, '0, '0);
    chk("alu_first_wren", 64'(wren), 64'd1);
    chk("alu_first_addr", 64'(wr_addr), 64'd5);
    chk("alu_first_data", 64'(wr_data), 64'h69);
    idle(1);
    chk("alu_first_done", 64'(wren), 64'd0);

    // x0 writes are dropped on both paths
    cyc(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'h1);
    chk("x0_wren", 64'(wren), 64'd0);
    chk("x0_count", 64'(lsu_count), 64'd0);
    chk("x0_pending", 64'(pending), 64'd0);
    idle(2);

    // Four loads, fill behind a busy ALU then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd20, 32'hA0 + i, 1'b1, 5'(i + 1), 32'h10 + i);
    idle(8);

    // Starvation: one load held back by a continuous ALU stream
    cyc(1'b1, 5'd9, 32'h900, 1'b1, 5'd7, 32'h6500);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd9, 32'h900, 1'b0, '0, '0);
    chk("starve_stall", 64'(alu_stall), 64'd1);
    cyc(1'b1, 5'd9, 32'h900, 1'b0, '0, '0);
    chk("starve_head_addr", 64'(wr_addr), 64'd7);
    chk("starve_head_data", 64'(wr_data), 64'h6500);
    cyc(1'b1, 5'd9, 32'h900, 1'b0, '0, '0);
    chk("starve_alu_after", 64'(wr_addr), 64'd9);
    idle(3);

    // Full FIFO with concurrent dequeue, then pointer wrap across eight loads
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd30, 32'hC0 + i, 1'b1, 5'(i + 1), 32'h20 + i);
    chk("full_count", 64'(lsu_count), 64'd4);
    chk("full_ready", 64'(lsu_ready), 64'd0);
    cyc(1'b0, '0, '0, 1'b1, 5'd5, 32'h24);
    chk("full_count_deq", 64'(lsu_count), 64'd3);
    chk("full_ready_back", 64'(lsu_ready), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 5'(i + 5), 32'h24 + i);
    idle(8);

    // Asynchronous reset mid-stream
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB1);
    cyc(1'b1, 5'd12, 32'hA2, 1'b1, 5'd12, 32'hB2);
    cyc(1'b1, 5'd13, 32'hA3, 1'b1, 5'd13, 32'hB3);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_count", 64'(lsu_count), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    idle(4);

    // Randomized traffic; ALU inputs held while stalled
    r_av = 1'b0; r_ard = '0; r_ad = '0;
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        r_av  = ($urandom_range(0, 2) != 0);
        r_ard = 5'($urandom_range(0, 7));
        r_ad  = $urandom;
      end
      cyc(r_av, r_ard, r_ad, ($urandom_range(0, 4) < 3), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(10);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
